// File: rtl/gio_port_set.sv
// Address-decoded I/O port set: one writable output port C and two captured input ports A/B.
// Define GIO_INPUT_SYNC_EN to route porta_in/portb_in through 2-flop synchronizers.
module gio_port_set #(
  parameter logic [7:0]  PORTA_ADDR = 8'h01,
  parameter logic [7:0]  PORTB_ADDR = 8'h02,
  parameter logic [7:0]  PORTC_ADDR = 8'h05,
  parameter int unsigned IN_WIDTH   = 4,
  parameter int unsigned OUT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           address,
  input  logic [7:0]           value_in,
  input  logic                 wen,
  input  logic                 ren,
  input  logic [IN_WIDTH-1:0]  porta_in,
  input  logic [IN_WIDTH-1:0]  portb_in,
  output logic [OUT_WIDTH-1:0] portc_out,
  output logic [7:0]           port_out
);

  logic [IN_WIDTH-1:0]  w_pin_a;
  logic [IN_WIDTH-1:0]  w_pin_b;
  logic [IN_WIDTH-1:0]  r_cap_a;
  logic [IN_WIDTH-1:0]  r_cap_b;
  logic [OUT_WIDTH-1:0] r_port_c;
  logic [7:0]           w_read_data;

`ifdef GIO_INPUT_SYNC_EN
  logic [IN_WIDTH-1:0] r_sync_a1;
  logic [IN_WIDTH-1:0] r_sync_a2;
  logic [IN_WIDTH-1:0] r_sync_b1;
  logic [IN_WIDTH-1:0] r_sync_b2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_a1 <= '0;
      r_sync_a2 <= '0;
      r_sync_b1 <= '0;
      r_sync_b2 <= '0;
    end else begin
      r_sync_a1 <= porta_in;
      r_sync_a2 <= r_sync_a1;
      r_sync_b1 <= portb_in;
      r_sync_b2 <= r_sync_b1;
    end
  end

  assign w_pin_a = r_sync_a2;
  assign w_pin_b = r_sync_b2;
`else
  assign w_pin_a = porta_in;
  assign w_pin_b = portb_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_port_c <= '0;
      r_cap_a  <= '0;
      r_cap_b  <= '0;
    end else begin
      if (wen && (address == PORTC_ADDR)) r_port_c <= value_in[OUT_WIDTH-1:0];
      if (ren && (address == PORTA_ADDR)) r_cap_a <= w_pin_a;
      if (ren && (address == PORTB_ADDR)) r_cap_b <= w_pin_b;
    end
  end

  // Port A is decoded first so it wins if the two input addresses collide.
  always_comb begin
    w_read_data = '0;
    if (address == PORTA_ADDR) begin
      w_read_data[IN_WIDTH-1:0] = r_cap_a;
    end else if (address == PORTB_ADDR) begin
      w_read_data[IN_WIDTH-1:0] = r_cap_b;
    end
  end

  assign portc_out = r_port_c;
  assign port_out  = w_read_data;

endmodule

// File: tb/tb_gio_port_set.sv
// Bench for gio_port_set: directed literal checks plus randomized traffic against a
// behavioural model compared on every falling edge.
module tb_gio_port_set;

  localparam int unsigned InWidth  = 4;
  localparam int unsigned OutWidth = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [7:0]          address = 8'h00;
  logic [7:0]          value_in = 8'h00;
  logic                wen = 1'b0;
  logic                ren = 1'b0;
  logic [InWidth-1:0]  porta_in = '0;
  logic [InWidth-1:0]  portb_in = '0;
  logic [OutWidth-1:0] portc_out;
  logic [7:0]          port_out;

  int n_tests = 0;
  int n_fail  = 0;

  gio_port_set #(
    .PORTA_ADDR(8'h01),
    .PORTB_ADDR(8'h02),
    .PORTC_ADDR(8'h05),
    .IN_WIDTH  (InWidth),
    .OUT_WIDTH (OutWidth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .value_in (value_in),
    .wen      (wen),
    .ren      (ren),
    .porta_in (porta_in),
    .portb_in (portb_in),
    .portc_out(portc_out),
    .port_out (port_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: port state plus a short history of pin values at each edge.
  int        m_valid = 0;
  int        m_port_c = 0;
  int        m_cap_a = 0;
  int        m_cap_b = 0;
  int        hist_a[2] = '{0, 0};
  int        hist_b[2] = '{0, 0};
`ifdef GIO_INPUT_SYNC_EN
  localparam bit SyncEn = 1'b1;
`else
  localparam bit SyncEn = 1'b0;
`endif

  always @(posedge clk) begin
    int seen_a;
    int seen_b;
    if (rst) begin
      m_valid  = 1;
      m_port_c = 0;
      m_cap_a  = 0;
      m_cap_b  = 0;
      hist_a   = '{0, 0};
      hist_b   = '{0, 0};
    end else begin
      // With synchronizers the capture sees the pin value from two edges earlier.
      seen_a = SyncEn ? hist_a[1] : int'(porta_in);
      seen_b = SyncEn ? hist_b[1] : int'(portb_in);
      if (wen && address == 8'h05) m_port_c = int'(value_in) % (1 << OutWidth);
      if (ren && address == 8'h01) m_cap_a = seen_a;
      if (ren && address == 8'h02) m_cap_b = seen_b;
      hist_a[1] = hist_a[0];
      hist_a[0] = int'(porta_in);
      hist_b[1] = hist_b[0];
      hist_b[0] = int'(portb_in);
    end
  end

  function automatic int model_read(input logic [7:0] addr);
    if (addr == 8'h01) return m_cap_a;
    if (addr == 8'h02) return m_cap_b;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (m_valid != 0) begin
      n_tests++;
      if (int'(portc_out) != m_port_c) begin
        n_fail++;
        $display("FAIL model_portc t=%0t got=%02h want=%02h", $time, portc_out, m_port_c);
      end
      n_tests++;
      if (int'(port_out) != model_read(address)) begin
        n_fail++;
        $display("FAIL model_port_out t=%0t addr=%02h got=%02h want=%02h", $time, address,
                 port_out, model_read(address));
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%02h want=%02h", name, got, want);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    // 1: reset
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("reset_portc", portc_out, 8'h00);
    address = 8'h01; #1 check("reset_read_a", port_out, 8'h00);
    address = 8'h02; #1 check("reset_read_b", port_out, 8'h00);
    address = 8'h05; #1 check("reset_read_c", port_out, 8'h00);

    // 2: write to a non-C address is ignored
    address = 8'h01; value_in = 8'hDD; wen = 1'b1;
    step(1);
    wen = 1'b0;
    step(1);
    check("unmapped_write", portc_out, 8'h00);

    // 3: write to C, then hold
    address = 8'h05; wen = 1'b1;
    step(1);
    wen = 1'b0;
    check("write_c", portc_out, 8'hDD);
    step(1);
    check("write_c_hold", portc_out, 8'hDD);
    address = 8'h02; value_in = 8'h11;
    step(1);
    check("write_c_hold_addr", portc_out, 8'hDD);

    // 4: capture B then A; pins held long enough for either build
    porta_in = 4'hA; portb_in = 4'hB; address = 8'h02;
    step(3);
    check("b_no_ren", port_out, 8'h00);
    ren = 1'b1;
    step(1);
    ren = 1'b0;
    check("b_capture", port_out, 8'h0B);
    address = 8'h01; #1 check("a_no_ren", port_out, 8'h00);
    ren = 1'b1;
    step(1);
    ren = 1'b0;
    check("a_capture", port_out, 8'h0A);

    // 5: pin change without ren stays invisible
    porta_in = 4'h3;
    step(3);
    check("a_hold", port_out, 8'h0A);
    address = 8'h05; #1 check("read_c_addr", port_out, 8'h00);

    // 6: reset beats a simultaneous write
    rst = 1'b1; wen = 1'b1; value_in = 8'h77;
    step(1);
    rst = 1'b0; wen = 1'b0;
    check("reset_priority", portc_out, 8'h00);

    // Capture right after a pin change: synchronized build still sees the reset value
    porta_in = 4'h5; address = 8'h01; ren = 1'b1;
    step(1);
    check("sync_first", port_out, SyncEn ? 8'h00 : 8'h05);
    step(2);
    ren = 1'b0;
    check("sync_settled", port_out, 8'h05);

    // Randomized traffic, checked by the model on every falling edge
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0: address = 8'h01;
        1: address = 8'h02;
        2: address = 8'h05;
        default: address = 8'($urandom);
      endcase
      value_in = 8'($urandom);
      wen      = ($urandom_range(0, 2) == 0);
      ren      = ($urandom_range(0, 2) == 0);
      porta_in = InWidth'($urandom);
      portb_in = InWidth'($urandom);
      rst      = ($urandom_range(0, 60) == 0);
      step(1);
    end
    rst = 1'b0; wen = 1'b0; ren = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
